jt10_adpcm_div_arb: RTL and testbench
=====================================

// Module: jt10_adpcm_div_arb
// PURPOSE
//  Round-robin arbiter/sequencer sharing one serial restoring divider (d=a/b, a=b*d+r)
//  among NCH ADPCM requesters. Grants one request, launches the divider, waits for it to
//  finish, and returns quotient/remainder with a one-tick ack. Divide-by-zero bypasses the
//  divider. Sits between the ADPCM channel logic and the divider, in the cen domain.
// PARAMETERS
//  DW   16  operand/result width; must equal the attached divider's DW
//  NCH  6   number of requesters (>=2); CW=$clog2(NCH) is derived, not a parameter
// PORTS
//  rst_n       in   1        async active-low reset
//  clk         in   1        clock; all logic advances only when cen=1
//  cen         in   1        clock enable
//  req         in   NCH      per-requester request level
//  a_bus       in   NCH*DW   dividends; requester i at [i*DW +: DW]
//  b_bus       in   NCH*DW   divisors; same packing
//  ack         out  NCH      one-hot, one cen tick: result for requester i valid
//  done        out  1        OR of ack
//  q_ch        out  CW       requester index of current/last result
//  q_d         out  DW       quotient
//  q_r         out  DW       remainder
//  dz          out  1        last result was a divide-by-zero
//  busy        out  1        state != IDLE
//  div_start   out  1        divider start strobe (high exactly while state==LAUNCH)
//  div_a       out  DW       registered dividend to divider
//  div_b       out  DW       registered divisor to divider
//  div_d       in   DW       divider quotient
//  div_r       in   DW       divider remainder
//  div_working in   1        divider busy flag
// BEHAVIOUR
//  - Single clock clk; reset rst_n asynchronous, active-low. Reset: state=IDLE, ack=0,
//    done=0, dz=0, q_ch=0, q_d=0, q_r=0, div_a=0, div_b=0, rr pointer=NCH-1.
//    Reset mid-operation aborts: no ack issued; divider is reset by the same rst_n.
//  - cen=0: all state/outputs hold; ack/done stretch until the next cen tick.
//  - FSM (transitions on cen ticks): IDLE -> LAUNCH -> WAIT -> DONE -> IDLE.
//    IDLE: if |req, grant first set req[i] searching ptr+1, ptr+2 .. wrapping mod NCH;
//      ptr<=i, q_ch<=i, div_a<=a_i, div_b<=b_i.
//      If b_i==0: q_d<={DW{1'b1}}, q_r<=a_i, dz<=1, ack[i]<=1, -> DONE (skip divider).
//      Else -> LAUNCH. No req: stay.
//    LAUNCH: div_start=1 for this tick -> WAIT.
//    WAIT: while div_working=1 stay; on tick with div_working=0: q_d<=div_d, q_r<=div_r,
//      dz<=0, ack[q_ch]<=1 -> DONE.
//    DONE: ack<=0 -> IDLE. req is not sampled in LAUNCH/WAIT/DONE.
//  - Timing (grant at cen tick E0, b!=0): start sampled E1, divider works E2..E(DW+1),
//    ack/done high for tick after E(DW+2); next grant no earlier than E(DW+4).
//    b==0: ack high for tick after E0; next grant at E2.
//  - Requester holds req, a, b stable until its ack; drops req on ack. A req still high
//    at the next IDLE is a new request, but rr pointer gives other requesters priority.
//  - q_d/q_r/q_ch/dz hold their value after ack until the next result.
//  - div_a/div_b stay constant from grant until the next grant.
// TESTING (DW=16, NCH=3)
//  - req[1], a1=1000, b1=7 -> ack[1] at E18 tick, q_d=142, q_r=6, dz=0, q_ch=1.
//  - req[0], a0=16'hFFFF, b0=1 -> q_d=16'hFFFF, q_r=0; a0=5, b0=16'hFFFF -> q_d=0, q_r=5.
//  - req[2], a2=16'h1234, b2=0 -> ack[2] next tick, q_d=16'hFFFF, q_r=16'h1234, dz=1,
//    div_start never asserted.
//  - req=3'b111 held, each drops on its ack -> grant order 0,1,2; then req 0 and 2
//    re-raised together after ch2 served -> order 0 then 2; no requester starved.
//  - Assert rst_n=0 during WAIT -> all outputs to reset values, no ack; after release a
//    fresh req completes normally with correct result.
//  - cen toggled 1/0 alternately through a 50/3 op -> q_d=16, q_r=2, ack lasts 2 clk.

Source files
------------

// File: rtl/jt10_adpcm_div_arb.sv
// jt10_adpcm_div_arb
//   Round-robin arbiter/sequencer that shares one serial restoring divider
//   (d = a/b, a = b*d + r) among NCH ADPCM requesters. It grants one request,
//   launches the divider, waits for it to finish, then returns the quotient and
//   remainder with a one-tick ack. A zero divisor skips the divider entirely.
//   All state advances only on cen ticks.
// Ports
//   clk, rst_n, cen           clock, async active-low reset, clock enable
//   req[NCH]                  per-requester request level
//   a_bus, b_bus              packed dividends/divisors, requester i at [i*DW +: DW]
//   ack[NCH], done            one-hot result strobe and its OR
//   q_ch, q_d, q_r, dz        result channel, quotient, remainder, divide-by-zero flag
//   busy                      sequencer not idle
//   div_start, div_a, div_b   divider launch strobe and registered operands
//   div_d, div_r, div_working divider results and busy flag
module jt10_adpcm_div_arb #(
    parameter int DW  = 16,
    parameter int NCH = 6,
    localparam int CW = $clog2(NCH)
) (
    input  logic              rst_n,
    input  logic              clk,
    input  logic              cen,
    input  logic [NCH-1:0]    req,
    input  logic [NCH*DW-1:0] a_bus,
    input  logic [NCH*DW-1:0] b_bus,
    output logic [NCH-1:0]    ack,
    output logic              done,
    output logic [CW-1:0]     q_ch,
    output logic [DW-1:0]     q_d,
    output logic [DW-1:0]     q_r,
    output logic              dz,
    output logic              busy,
    output logic              div_start,
    output logic [DW-1:0]     div_a,
    output logic [DW-1:0]     div_b,
    input  logic [DW-1:0]     div_d,
    input  logic [DW-1:0]     div_r,
    input  logic              div_working
);

    typedef enum logic [1:0] {S_IDLE, S_LAUNCH, S_WAIT, S_DONE} state_t;

    state_t          state, nxt;
    logic [CW-1:0]   ptr;
    logic [CW-1:0]   gnt_idx;
    logic            gnt_found;
    logic [DW-1:0]   a_arr [NCH];
    logic [DW-1:0]   b_arr [NCH];

    for (genvar g = 0; g < NCH; g++) begin : g_unpack
        assign a_arr[g] = a_bus[g*DW +: DW];
        assign b_arr[g] = b_bus[g*DW +: DW];
    end

    // Search starts just after the last granted requester, so the one served
    // last has the lowest priority next time.
    always_comb begin
        logic [CW-1:0] idx;
        gnt_found = 1'b0;
        gnt_idx   = ptr;
        idx       = ptr;
        for (int k = 0; k < NCH; k++) begin
            idx = (idx == CW'(NCH-1)) ? '0 : idx + CW'(1);
            if (!gnt_found && req[idx]) begin
                gnt_found = 1'b1;
                gnt_idx   = idx;
            end
        end
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)   state <= S_IDLE;
        else if (cen) state <= nxt;
    end

    // Next-state logic
    always_comb begin
        nxt = state;
        case (state)
            S_IDLE:   if (gnt_found) nxt = (b_arr[gnt_idx] == '0) ? S_DONE : S_LAUNCH;
            S_LAUNCH: nxt = S_WAIT;
            S_WAIT:   if (!div_working) nxt = S_DONE;
            S_DONE:   nxt = S_IDLE;
            default:  nxt = S_IDLE;
        endcase
    end

    // Outputs decoded from state
    always_comb begin
        busy      = (state != S_IDLE);
        div_start = (state == S_LAUNCH);
    end

    assign done = |ack;

    // Datapath: grant capture, results and ack strobe
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr   <= CW'(NCH-1);
            q_ch  <= '0;
            q_d   <= '0;
            q_r   <= '0;
            dz    <= 1'b0;
            div_a <= '0;
            div_b <= '0;
            ack   <= '0;
        end else if (cen) begin
            case (state)
                S_IDLE: if (gnt_found) begin
                    ptr   <= gnt_idx;
                    q_ch  <= gnt_idx;
                    div_a <= a_arr[gnt_idx];
                    div_b <= b_arr[gnt_idx];
                    if (b_arr[gnt_idx] == '0) begin
                        // Divide-by-zero: saturate quotient, pass dividend through
                        q_d <= '1;
                        q_r <= a_arr[gnt_idx];
                        dz  <= 1'b1;
                        ack <= NCH'(1) << gnt_idx;
                    end
                end
                S_WAIT: if (!div_working) begin
                    q_d <= div_d;
                    q_r <= div_r;
                    dz  <= 1'b0;
                    ack <= NCH'(1) << q_ch;
                end
                S_DONE:  ack <= '0;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_jt10_adpcm_div_arb.sv
module tb_jt10_adpcm_div_arb;
    localparam int DW  = 16;
    localparam int NCH = 3;
    localparam int CW  = $clog2(NCH);

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              cen = 1'b1;
    logic              cen_alt = 1'b0;
    logic [NCH-1:0]    req = '0;
    logic [NCH*DW-1:0] a_bus = '0;
    logic [NCH*DW-1:0] b_bus = '0;
    logic [NCH-1:0]    ack;
    logic              done;
    logic [CW-1:0]     q_ch;
    logic [DW-1:0]     q_d, q_r;
    logic              dz, busy, div_start;
    logic [DW-1:0]     div_a, div_b;
    logic [DW-1:0]     div_d, div_r;
    logic              div_working;

    int n_checks = 0;
    int n_fail   = 0;
    int start_cnt = 0;

    jt10_adpcm_div_arb #(.DW(DW), .NCH(NCH)) dut (
        .rst_n(rst_n), .clk(clk), .cen(cen), .req(req), .a_bus(a_bus), .b_bus(b_bus),
        .ack(ack), .done(done), .q_ch(q_ch), .q_d(q_d), .q_r(q_r), .dz(dz), .busy(busy),
        .div_start(div_start), .div_a(div_a), .div_b(div_b), .div_d(div_d), .div_r(div_r),
        .div_working(div_working)
    );

    always #5 clk = ~clk;

    // cen either stuck high or alternating 1/0 each clock
    always @(negedge clk) cen = cen_alt ? ~cen : 1'b1;

    // Behavioural serial divider: samples start, stays busy for DW ticks.
    logic [4:0] dcnt;
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_working <= 1'b0; dcnt <= '0; div_d <= '0; div_r <= '0;
        end else if (cen) begin
            if (div_start) begin
                div_working <= 1'b1; dcnt <= '0; div_d <= '0; div_r <= '0;
            end else if (div_working) begin
                dcnt <= dcnt + 5'd1;
                if (dcnt == 5'(DW-1)) begin
                    div_working <= 1'b0;
                    if (div_b != 0) begin
                        div_d <= div_a / div_b;
                        div_r <= div_a % div_b;
                    end
                end
            end
        end
    end

    always @(posedge clk) if (cen && div_start) start_cnt <= start_cnt + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic set_ch(input int ch, input logic [DW-1:0] a, input logic [DW-1:0] b);
        a_bus[ch*DW +: DW] = a;
        b_bus[ch*DW +: DW] = b;
    endtask

    // Waits for an ack, drops that requester's req, then measures ack length.
    task automatic wait_op(input int budget, output int lat, output int len,
                           output logic [NCH-1:0] ackv);
        lat = 0; len = 0; ackv = '0;
        while (lat < budget) begin
            @(posedge clk); #1;
            lat++;
            if (ack != 0) begin ackv = ack; break; end
        end
        if (ackv != 0) begin
            req = req & ~ackv;
            len = 1;
            for (int i = 0; i < 8; i++) begin
                @(posedge clk); #1;
                if (ack != 0) len++; else break;
            end
        end
    endtask

    task automatic check_result(input string tag, input logic [NCH-1:0] ackv, input int ch,
                                input logic [DW-1:0] d, input logic [DW-1:0] r, input logic z);
        check({tag, "_ack"},  32'(ackv), 32'(1 << ch));
        check({tag, "_qch"},  32'(q_ch), 32'(ch));
        check({tag, "_qd"},   32'(q_d), 32'(d));
        check({tag, "_qr"},   32'(q_r), 32'(r));
        check({tag, "_dz"},   32'(dz), 32'(z));
    endtask

    initial begin
        int lat, len, s0;
        logic [NCH-1:0] av;
        int order [3];

        // Reset state
        #1;
        check("rst_ack", 32'(ack), 0);
        check("rst_done", 32'(done), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_qd", 32'(q_d), 0);
        check("rst_diva", 32'(div_a), 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // 1000/7 on ch1, exact latency
        set_ch(1, 16'd1000, 16'd7);
        req = 3'b010;
        wait_op(40, lat, len, av);
        check("t1_lat", 32'(lat), 19);
        check("t1_len", 32'(len), 1);
        check_result("t1", av, 1, 16'd142, 16'd6, 1'b0);
        check("t1_diva", 32'(div_a), 32'd1000);
        check("t1_divb", 32'(div_b), 32'd7);
        check("t1_done_low", 32'(done), 0);

        // Boundary operands on ch0
        set_ch(0, 16'hFFFF, 16'd1);
        req = 3'b001;
        wait_op(40, lat, len, av);
        check_result("t2a", av, 0, 16'hFFFF, 16'd0, 1'b0);
        set_ch(0, 16'd5, 16'hFFFF);
        req = 3'b001;
        wait_op(40, lat, len, av);
        check_result("t2b", av, 0, 16'd0, 16'd5, 1'b0);

        // Divide by zero on ch2: bypasses divider
        s0 = start_cnt;
        set_ch(2, 16'h1234, 16'd0);
        req = 3'b100;
        wait_op(40, lat, len, av);
        check("dz_lat", 32'(lat), 1);
        check_result("dz", av, 2, 16'hFFFF, 16'h1234, 1'b1);
        repeat (2) @(posedge clk);
        #1;
        check("dz_nostart", 32'(start_cnt - s0), 0);

        // Reset during WAIT
        set_ch(1, 16'd1000, 16'd7);
        req = 3'b010;
        repeat (8) @(posedge clk);
        #1;
        check("pre_rst_busy", 32'(busy), 1);
        rst_n = 1'b0;
        #1;
        check("mid_rst_ack", 32'(ack), 0);
        check("mid_rst_busy", 32'(busy), 0);
        check("mid_rst_dz", 32'(dz), 0);
        check("mid_rst_qch", 32'(q_ch), 0);
        check("mid_rst_qd", 32'(q_d), 0);
        check("mid_rst_qr", 32'(q_r), 0);
        check("mid_rst_divb", 32'(div_b), 0);
        check("mid_rst_start", 32'(div_start), 0);
        req = 3'b000;
        repeat (3) @(posedge clk);
        #1;
        check("mid_rst_ack2", 32'(ack), 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        set_ch(2, 16'd42, 16'd5);
        req = 3'b100;
        wait_op(40, lat, len, av);
        check("post_rst_lat", 32'(lat), 19);
        check_result("post_rst", av, 2, 16'd8, 16'd2, 1'b0);

        // Round robin with all three requesting
        set_ch(0, 16'd100, 16'd10);
        set_ch(1, 16'd77, 16'd5);
        set_ch(2, 16'd9, 16'd4);
        req = 3'b111;
        for (int i = 0; i < 3; i++) begin
            wait_op(40, lat, len, av);
            order[i] = (av == 3'b001) ? 0 : (av == 3'b010) ? 1 : (av == 3'b100) ? 2 : 9;
            if (i == 1) check("rr_ch1_qd", 32'(q_d), 32'd15);
        end
        check("rr_ord0", 32'(order[0]), 0);
        check("rr_ord1", 32'(order[1]), 1);
        check("rr_ord2", 32'(order[2]), 2);
        check("rr_ch2_qr", 32'(q_r), 32'd1);
        req = 3'b101;
        wait_op(40, lat, len, av);
        check_result("rr2a", av, 0, 16'd10, 16'd0, 1'b0);
        wait_op(40, lat, len, av);
        check_result("rr2b", av, 2, 16'd2, 16'd1, 1'b0);

        // Alternating cen through 50/3
        cen_alt = 1'b1;
        @(negedge clk);
        @(negedge clk);
        set_ch(1, 16'd50, 16'd3);
        req = 3'b010;
        wait_op(80, lat, len, av);
        check("cen_len", 32'(len), 2);
        check_result("cen", av, 1, 16'd16, 16'd2, 1'b0);
        cen_alt = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        check("end_idle", 32'(busy), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
